// File: rtl/regbank_access_arbiter.sv
// Two-requester arbiter in front of a shared bank of tri-state registers.
// One access at a time is serialised through IDLE -> ACCESS -> DONE, stepped by Tick.
module regbank_access_arbiter #(
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [AddrBits-1:0] a_addr,
    input  logic [NrOfBits-1:0] a_wdata,
    output logic                a_gnt,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [AddrBits-1:0] b_addr,
    input  logic [NrOfBits-1:0] b_wdata,
    output logic                b_gnt,
    output logic [NrOfBits-1:0] rdata,
    output logic                err,
    output logic [NrOfRegs-1:0] bank_ce,
    output logic [NrOfRegs-1:0] bank_cs,
    output logic [NrOfBits-1:0] bank_d,
    input  logic [NrOfBits-1:0] bank_q
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;
    // Register count widened by one bit so it always fits next to the address.
    localparam logic [AddrBits:0] NR_REGS_W = NrOfRegs[AddrBits:0];

    state_e                state_q,      state_d;
    logic                  owner_q,      owner_d;
    logic                  we_q,         we_d;
    logic [AddrBits-1:0]   addr_q,       addr_d;
    logic [NrOfBits-1:0]   wdata_q,      wdata_d;
    logic                  last_owner_q, last_owner_d;
    logic [NrOfBits-1:0]   rdata_q,      rdata_d;
    logic                  err_q,        err_d;
    logic                  a_gnt_q,      a_gnt_d;
    logic                  b_gnt_q,      b_gnt_d;

    logic                  in_range_s;
    logic                  sel_s;
    logic [NrOfRegs-1:0]   onehot_s;
    logic [NrOfRegs-1:0]   bank_ce_s;
    logic [NrOfRegs-1:0]   bank_cs_s;
    logic [NrOfBits-1:0]   bank_d_s;

    assign in_range_s = ({1'b0, addr_q} < NR_REGS_W);

    // Decode the latched address into a one-hot register select.
    always_comb begin
        onehot_s = {NrOfRegs{1'b0}};
        for (int i = 0; i < NrOfRegs; i++) begin
            onehot_s[i] = (addr_q == AddrBits'(i));
        end
    end

    // Round-robin pick: on a tie, the requester that was not served last wins.
    always_comb begin
        if (a_req && b_req) begin
            sel_s = ~last_owner_q;
        end else if (a_req) begin
            sel_s = OWNER_A;
        end else begin
            sel_s = OWNER_B;
        end
    end

    // Next-state and registered-field update logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_owner_d = last_owner_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        a_gnt_d      = 1'b0;
        b_gnt_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Tick && (a_req || b_req)) begin
                    owner_d = sel_s;
                    if (sel_s == OWNER_B) begin
                        we_d    = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end else begin
                        we_d    = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (Tick) begin
                    if (!we_q) begin
                        rdata_d = in_range_s ? bank_q : {NrOfBits{1'b0}};
                    end else begin
                        rdata_d = rdata_q;
                    end
                    err_d        = ~in_range_s;
                    last_owner_d = owner_q;
                    a_gnt_d      = (owner_q == OWNER_A);
                    b_gnt_d      = (owner_q == OWNER_B);
                    state_d      = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-field registers with asynchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_A;
            we_q         <= 1'b0;
            addr_q       <= {AddrBits{1'b0}};
            wdata_q      <= {NrOfBits{1'b0}};
            last_owner_q <= OWNER_B;
            rdata_q      <= {NrOfBits{1'b0}};
            err_q        <= 1'b0;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_owner_q <= last_owner_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            a_gnt_q      <= a_gnt_d;
            b_gnt_q      <= b_gnt_d;
        end
    end

    // Bank controls follow the state register, so an async reset drops them at once.
    always_comb begin
        bank_ce_s = {NrOfRegs{1'b0}};
        bank_cs_s = {NrOfRegs{1'b1}};
        bank_d_s  = {NrOfBits{1'b0}};
        if ((state_q == ST_ACCESS) && in_range_s) begin
            if (we_q) begin
                bank_ce_s = onehot_s;
                bank_d_s  = wdata_q;
            end else begin
                bank_cs_s = ~onehot_s;
            end
        end else begin
            bank_ce_s = {NrOfRegs{1'b0}};
        end
    end

    assign bank_ce = bank_ce_s;
    assign bank_cs = bank_cs_s;
    assign bank_d  = bank_d_s;
    assign a_gnt   = a_gnt_q;
    assign b_gnt   = b_gnt_q;
    assign rdata   = rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Directed bench for regbank_access_arbiter with a behavioural tri-state register bank.
module tb_regbank_access_arbiter;

    localparam int NR = 8;
    localparam int AB = 4;
    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          a_req, a_we, b_req, b_we;
    logic [AB-1:0] a_addr, b_addr;
    logic [NB-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, err;
    logic [NB-1:0] rdata, bank_d, bank_q;
    logic [NR-1:0] bank_ce, bank_cs;

    logic          bank_init;
    logic [NB-1:0] regs [NR];
    int            wr_count [NR];
    logic [NB-1:0] q_mux;

    int err_cnt = 0;
    int chk_cnt = 0;
    int overlap_cnt = 0;
    int cs_viol_cnt = 0;

    always #5 clk = ~clk;

    regbank_access_arbiter #(.NrOfRegs(NR), .AddrBits(AB), .NrOfBits(NB)) dut (
        .Clock(clk), .Reset(rst), .Tick(tick),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .rdata(rdata), .err(err),
        .bank_ce(bank_ce), .bank_cs(bank_cs), .bank_d(bank_d), .bank_q(bank_q)
    );

    // Bank model: each register captures D on a Tick edge while its ClockEnable is high.
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bank_init) begin
                regs[i]     <= 32'h1000_0000 + 32'(i);
                wr_count[i] <= 0;
            end else if (bank_ce[i] && tick) begin
                regs[i]     <= bank_d;
                wr_count[i] <= wr_count[i] + 1;
            end
        end
    end

    always_comb begin
        q_mux = 'z;
        for (int i = 0; i < NR; i++) begin
            if (!bank_cs[i]) q_mux = regs[i];
        end
    end
    assign bank_q = q_mux;

    // Bus-safety monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (a_gnt && b_gnt) overlap_cnt <= overlap_cnt + 1;
        if (!$onehot0(~bank_cs) || ((~bank_cs != '0) && (bank_ce != '0)))
            cs_viol_cnt <= cs_viol_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    int         gnt_cyc [$];
    logic       gnt_own [$];
    int         exp_cyc [4] = '{2, 5, 8, 11};
    logic       exp_own [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         wc_before;
    int         gnt_seen;
    int         gnt_k;

    initial begin
        rst = 1'b1; tick = 1'b1; bank_init = 1'b1;
        idle_reqs();
        step(); step();
        check_eq("rst_ce",    64'(bank_ce), 64'h00);
        check_eq("rst_cs",    64'(bank_cs), 64'hFF);
        check_eq("rst_d",     64'(bank_d),  64'h0);
        check_eq("rst_gnt",   64'({a_gnt, b_gnt}), 64'h0);
        check_eq("rst_rdata", 64'(rdata),   64'h0);
        check_eq("rst_err",   64'(err),     64'h0);
        rst = 1'b0; bank_init = 1'b0;

        // A writes addr 3 then reads it back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'hDEADBEEF;
        step();
        check_eq("w3_ce",  64'(bank_ce), 64'h08);
        check_eq("w3_d",   64'(bank_d),  64'hDEADBEEF);
        check_eq("w3_gnt_early", 64'(a_gnt), 64'h0);
        step();
        check_eq("w3_gnt", 64'(a_gnt), 64'h1);
        check_eq("w3_err", 64'(err),   64'h0);
        check_eq("w3_ce_off", 64'(bank_ce), 64'h00);
        check_eq("w3_reg", 64'(regs[3]), 64'hDEADBEEF);
        a_req = 1'b0;
        step();
        check_eq("w3_gnt_pulse", 64'(a_gnt), 64'h0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        step();
        check_eq("r3_cs", 64'(bank_cs), 64'hF7);
        check_eq("r3_ce", 64'(bank_ce), 64'h00);
        step();
        check_eq("r3_gnt",   64'(a_gnt), 64'h1);
        check_eq("r3_rdata", 64'(rdata), 64'hDEADBEEF);
        a_req = 1'b0;
        step();

        // Fresh reset, then both requesters read continuously: A,B,A,B.
        rst = 1'b1; step(); rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (a_gnt) begin
                gnt_cyc.push_back(k); gnt_own.push_back(1'b0);
                check_eq("rr_a_rdata", 64'(rdata), 64'h1000_0001);
            end
            if (b_gnt) begin
                gnt_cyc.push_back(k); gnt_own.push_back(1'b1);
                check_eq("rr_b_rdata", 64'(rdata), 64'h1000_0002);
            end
        end
        idle_reqs();
        check_eq("rr_count", 64'(gnt_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gnt_cyc.size()) begin
                check_eq("rr_cycle", 64'(gnt_cyc[i]), 64'(exp_cyc[i]));
                check_eq("rr_owner", 64'(gnt_own[i]), 64'(exp_own[i]));
            end
        end
        step(); step();

        // Tick one clock in four; B writes 1 to addr 7.
        wc_before = wr_count[7];
        gnt_seen = 0; gnt_k = -1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 32'h1;
        for (int k = 0; k <= 10; k++) begin
            tick = ((k % 4) == 3);
            step();
            if (k >= 4 && k <= 6) begin
                check_eq("tk_ce_hold", 64'(bank_ce), 64'h80);
                check_eq("tk_d_hold",  64'(bank_d),  64'h1);
            end
            if (b_gnt) begin
                gnt_seen++; gnt_k = k;
                b_req = 1'b0;
            end
        end
        tick = 1'b1;
        check_eq("tk_gnt_count", 64'(gnt_seen), 64'd1);
        check_eq("tk_gnt_cycle", 64'(gnt_k), 64'd7);
        check_eq("tk_writes",    64'(wr_count[7] - wc_before), 64'd1);
        check_eq("tk_reg7",      64'(regs[7]), 64'h1);
        idle_reqs();
        step();

        // Out-of-range read of addr 9.
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd9;
        step();
        check_eq("oor_cs", 64'(bank_cs), 64'hFF);
        check_eq("oor_ce", 64'(bank_ce), 64'h00);
        step();
        check_eq("oor_gnt",   64'(a_gnt), 64'h1);
        check_eq("oor_err",   64'(err),   64'h1);
        check_eq("oor_rdata", 64'(rdata), 64'h0);
        idle_reqs();
        step();

        // Reset asserted while an A write sits in ACCESS.
        wc_before = wr_count[4];
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd4; a_wdata = 32'h55AA55AA;
        step();
        check_eq("ra_ce_before", 64'(bank_ce), 64'h10);
        #2 rst = 1'b1;
        #1;
        check_eq("ra_ce_async", 64'(bank_ce), 64'h00);
        check_eq("ra_cs_async", 64'(bank_cs), 64'hFF);
        step();
        check_eq("ra_no_gnt", 64'(a_gnt), 64'h0);
        idle_reqs();
        rst = 1'b0;
        check_eq("ra_reg4",   64'(regs[4]), 64'h1000_0004);
        check_eq("ra_writes", 64'(wr_count[4] - wc_before), 64'd0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd1;
        step(); step();
        check_eq("ra_first_a", 64'({a_gnt, b_gnt}), 64'b10);
        check_eq("ra_rdata",   64'(rdata), 64'h1000_0000);
        idle_reqs();
        step(); step();

        // Address changed right after the grant must be ignored.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 32'h0000_0022;
        step();
        a_addr = 4'd5;
        #1;
        check_eq("lat_ce", 64'(bank_ce), 64'h04);
        step();
        check_eq("lat_gnt",  64'(a_gnt),   64'h1);
        check_eq("lat_reg2", 64'(regs[2]), 64'h22);
        check_eq("lat_reg5", 64'(regs[5]), 64'h1000_0005);
        idle_reqs();
        step(); step();

        check_eq("gnt_overlap", 64'(overlap_cnt), 64'd0);
        check_eq("cs_ce_rules", 64'(cs_viol_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
